// File: rtl/fuzzy_entrada_cond.sv
// Input conditioner for Fuzzy_1: averages 2**AVG_LOG2 sample pairs, clamps and holds the result.
// Optional feature: define FUZZY_ENT_SKIP_IGUAL_EN to drop updates that repeat the current Entrada values.
module fuzzy_entrada_cond #(
  parameter int AVG_LOG2 = 2,
  parameter int HOLD_CYC = 16,
  parameter int MIN_VAL  = 1,
  parameter int MAX_VAL  = 254
) (
  input  logic       clk_0,
  input  logic       Srst_n,
  input  logic       amostra_valida,
  input  logic [7:0] amostra_01,
  input  logic [7:0] amostra_02,
  output logic       amostra_pronta,
  output logic [7:0] Entrada_01,
  output logic [7:0] Entrada_02,
  output logic       nova_entrada,
  output logic       ocupado
);

  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [7:0]    MIN_B     = 8'(MIN_VAL);
  localparam logic [7:0]    MAX_B     = 8'(MAX_VAL);

  typedef enum logic [1:0] {ACUM, MEDIA, APLICA, ESPERA} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_01_q, acc_01_d, acc_02_q, acc_02_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [7:0]      ent_01_q, ent_01_d, ent_02_q, ent_02_d;
  logic            nova_q, nova_d;
  logic            pronta_q, pronta_d;
  logic            accept;
  logic [7:0]      avg_01, avg_02, clamp_01, clamp_02;
  logic            skip_igual;

  assign accept = amostra_valida & pronta_q;

  // acc stays untouched from MEDIA through APLICA, so the clamped average can be derived combinationally
  always_comb begin
    avg_01   = 8'(acc_01_q >> AVG_LOG2);
    avg_02   = 8'(acc_02_q >> AVG_LOG2);
    clamp_01 = (avg_01 < MIN_B) ? MIN_B : ((avg_01 > MAX_B) ? MAX_B : avg_01);
    clamp_02 = (avg_02 < MIN_B) ? MIN_B : ((avg_02 > MAX_B) ? MAX_B : avg_02);
`ifdef FUZZY_ENT_SKIP_IGUAL_EN
    skip_igual = (clamp_01 == ent_01_q) && (clamp_02 == ent_02_q);
`else
    skip_igual = 1'b0;
`endif
  end

  always_ff @(posedge clk_0 or negedge Srst_n) begin
    if (!Srst_n) begin
      state_q  <= ACUM;
      acc_01_q <= '0;
      acc_02_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      ent_01_q <= MIN_B;
      ent_02_q <= MIN_B;
      nova_q   <= 1'b0;
      pronta_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_01_q <= acc_01_d;
      acc_02_q <= acc_02_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      ent_01_q <= ent_01_d;
      ent_02_q <= ent_02_d;
      nova_q   <= nova_d;
      pronta_q <= pronta_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACUM:    if (accept && (cnt_q == CNT_LAST)) state_d = MEDIA;
      MEDIA:   state_d = skip_igual ? ACUM : APLICA;
      APLICA:  state_d = ESPERA;
      ESPERA:  if (hold_q == '0) state_d = ACUM;
      default: state_d = ACUM;
    endcase
  end

  // pronta is registered so it stays low through the first cycle after reset release
  always_comb begin
    acc_01_d = acc_01_q;
    acc_02_d = acc_02_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    ent_01_d = ent_01_q;
    ent_02_d = ent_02_q;
    nova_d   = 1'b0;
    pronta_d = (state_d == ACUM);
    case (state_q)
      ACUM: begin
        if (accept) begin
          acc_01_d = acc_01_q + AW'(amostra_01);
          acc_02_d = acc_02_q + AW'(amostra_02);
          cnt_d    = cnt_q + CW'(1);
        end
      end
      MEDIA: begin
        if (skip_igual) begin
          acc_01_d = '0;
          acc_02_d = '0;
          cnt_d    = '0;
        end
      end
      APLICA: begin
        ent_01_d = clamp_01;
        ent_02_d = clamp_02;
        nova_d   = 1'b1;
        hold_d   = HOLD_LOAD;
      end
      ESPERA: begin
        if (hold_q == '0) begin
          acc_01_d = '0;
          acc_02_d = '0;
          cnt_d    = '0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: ;
    endcase
  end

  assign amostra_pronta = pronta_q;
  assign Entrada_01     = ent_01_q;
  assign Entrada_02     = ent_02_q;
  assign nova_entrada   = nova_q;
  assign ocupado        = (state_q != ACUM);

endmodule

// File: tb/tb_fuzzy_entrada_cond.sv
// Testbench for fuzzy_entrada_cond: directed and random steps checked every cycle against a transaction-level model.
module tb_fuzzy_entrada_cond;

  localparam int AVG_LOG2 = 2;
  localparam int HOLD_CYC = 16;
  localparam int MIN_VAL  = 1;
  localparam int MAX_VAL  = 254;
  localparam int N        = 1 << AVG_LOG2;

  logic       clk_0 = 1'b0;
  logic       Srst_n = 1'b0;
  logic       amostra_valida = 1'b0;
  logic [7:0] amostra_01 = '0;
  logic [7:0] amostra_02 = '0;
  logic       amostra_pronta;
  logic [7:0] Entrada_01, Entrada_02;
  logic       nova_entrada, ocupado;

  always #5 clk_0 = ~clk_0;

  fuzzy_entrada_cond #(
    .AVG_LOG2(AVG_LOG2), .HOLD_CYC(HOLD_CYC), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL)
  ) dut (
    .clk_0(clk_0), .Srst_n(Srst_n), .amostra_valida(amostra_valida),
    .amostra_01(amostra_01), .amostra_02(amostra_02), .amostra_pronta(amostra_pronta),
    .Entrada_01(Entrada_01), .Entrada_02(Entrada_02),
    .nova_entrada(nova_entrada), .ocupado(ocupado)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: ready flag, remaining not-ready cycles, pending update countdown, accepted samples
  bit m_ready, m_gap, m_nova;
  int m_low_left, m_apply_in, m_e1, m_e2, m_p1, m_p2;
  int q1[$];
  int q2[$];
  int nova_count, low_count;

  function automatic int clampv(input int v);
    if (v < MIN_VAL) return MIN_VAL;
    if (v > MAX_VAL) return MAX_VAL;
    return v;
  endfunction

  task automatic modelReset();
    m_ready = 0; m_gap = 1; m_nova = 0;
    m_low_left = 0; m_apply_in = 0;
    m_e1 = MIN_VAL; m_e2 = MIN_VAL;
    q1.delete(); q2.delete();
  endtask

  task automatic modelEdge(input bit v, input int a, input int b);
    int s1, s2, c1, c2;
    bit skip;
    m_nova = 0;
    if (m_apply_in > 0) begin
      m_apply_in--;
      if (m_apply_in == 0) begin
        m_e1 = m_p1; m_e2 = m_p2; m_nova = 1;
      end
    end
    if (m_gap) begin
      m_gap = 0; m_ready = 1;
    end else if (m_low_left > 0) begin
      m_low_left--;
      if (m_low_left == 0) m_ready = 1;
    end else if (m_ready && v) begin
      q1.push_back(a); q2.push_back(b);
      if (q1.size() == N) begin
        s1 = 0; s2 = 0;
        foreach (q1[i]) begin s1 += q1[i]; s2 += q2[i]; end
        c1 = clampv(s1 / N); c2 = clampv(s2 / N);
        q1.delete(); q2.delete();
        m_ready = 0;
        skip = 0;
`ifdef FUZZY_ENT_SKIP_IGUAL_EN
        skip = (c1 == m_e1) && (c2 == m_e2);
`endif
        if (skip) m_low_left = 1;
        else begin
          m_low_left = HOLD_CYC + 2;
          m_apply_in = 2;
          m_p1 = c1; m_p2 = c2;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string step);
    checkOutput({step, ".pronta"}, {7'b0, amostra_pronta}, {7'b0, m_ready});
    checkOutput({step, ".e1"}, Entrada_01, 8'(m_e1));
    checkOutput({step, ".e2"}, Entrada_02, 8'(m_e2));
    checkOutput({step, ".nova"}, {7'b0, nova_entrada}, {7'b0, m_nova});
    checkOutput({step, ".ocupado"}, {7'b0, ocupado}, {7'b0, (m_low_left > 0) && !m_gap});
  endtask

  task automatic applyStimulus(input bit v, input int a, input int b, input string step);
    amostra_valida = v;
    amostra_01 = 8'(a);
    amostra_02 = 8'(b);
    @(posedge clk_0);
    modelEdge(v, a, b);
    #1;
    if (m_nova) nova_count++;
    if (!amostra_pronta) low_count++;
    checkAll(step);
  endtask

  task automatic idle(input int n, input string step);
    for (int i = 0; i < n; i++) applyStimulus(0, $urandom_range(0, 255), $urandom_range(0, 255), step);
  endtask

  task automatic burst(input int a, input int b, input string step);
    for (int i = 0; i < N; i++) applyStimulus(1, a, b, step);
  endtask

  initial begin
    int r1, r2;
    modelReset();
    #12;
    checkAll("rst0");
    @(negedge clk_0);
    Srst_n = 1'b1;
    applyStimulus(1, 77, 77, "gap0");

    // T2 nominal
    nova_count = 0; low_count = 0;
    burst(144, 192, "T2");
    idle(20, "T2i");
    checkOutput("T2.e1", Entrada_01, 8'd144);
    checkOutput("T2.e2", Entrada_02, 8'd192);
    checkOutput("T2.nova_count", 8'(nova_count), 8'd1);
    checkOutput("T2.low_cycles", 8'(low_count), 8'(HOLD_CYC + 2));

    // T3 clamp and in-range
    burst(0, 255, "T3a");
    idle(20, "T3ai");
    checkOutput("T3a.e1", Entrada_01, 8'd1);
    checkOutput("T3a.e2", Entrada_02, 8'd254);
    burst(3, 250, "T3b");
    idle(20, "T3bi");
    checkOutput("T3b.e1", Entrada_01, 8'd3);
    checkOutput("T3b.e2", Entrada_02, 8'd250);

    // T4 truncation
    applyStimulus(1, 10, 100, "T4");
    applyStimulus(1, 11, 100, "T4");
    applyStimulus(1, 11, 100, "T4");
    applyStimulus(1, 11, 100, "T4");
    idle(20, "T4i");
    checkOutput("T4.e1", Entrada_01, 8'd10);
    checkOutput("T4.e2", Entrada_02, 8'd100);

    // T5 valid held during busy period, then gapped transfers
    burst(200, 200, "T5a");
    for (int i = 0; i < HOLD_CYC + 2; i++)
      applyStimulus(1, $urandom_range(0, 255), $urandom_range(0, 255), "T5busy");
    applyStimulus(1, 20, 40, "T5");
    applyStimulus(0, 0, 0, "T5");
    applyStimulus(1, 22, 44, "T5");
    applyStimulus(0, 99, 99, "T5");
    applyStimulus(0, 98, 98, "T5");
    applyStimulus(1, 24, 46, "T5");
    applyStimulus(1, 26, 48, "T5");
    idle(20, "T5i");
    checkOutput("T5.e1", Entrada_01, 8'd23);
    checkOutput("T5.e2", Entrada_02, 8'd44);

    // T6 repeated averages
    nova_count = 0;
    burst(144, 192, "T6a");
    idle(20, "T6ai");
    burst(144, 192, "T6b");
    idle(20, "T6bi");
`ifdef FUZZY_ENT_SKIP_IGUAL_EN
    checkOutput("T6.nova_count", 8'(nova_count), 8'd1);
`else
    checkOutput("T6.nova_count", 8'(nova_count), 8'd2);
`endif

    // T1 reset mid-accumulation
    applyStimulus(1, 250, 250, "T1pre");
    applyStimulus(1, 250, 250, "T1pre");
    Srst_n = 1'b0;
    #2;
    modelReset();
    checkAll("T1rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_0);
      #1;
      checkAll("T1hold");
    end
    @(negedge clk_0);
    Srst_n = 1'b1;
    applyStimulus(1, 200, 200, "T1gap");
    applyStimulus(1, 50, 60, "T1");
    applyStimulus(1, 52, 62, "T1");
    applyStimulus(1, 54, 64, "T1");
    applyStimulus(1, 56, 66, "T1");
    idle(20, "T1i");
    checkOutput("T1.e1", Entrada_01, 8'd53);
    checkOutput("T1.e2", Entrada_02, 8'd63);

    // Random phase with extreme values mixed in
    for (int i = 0; i < 500; i++) begin
      r1 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255) : $urandom_range(0, 255);
      r2 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255) : $urandom_range(0, 255);
      applyStimulus($urandom_range(0, 3) != 0, r1, r2, "RND");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
